plru_state_update: RTL and testbench

- Per-set tree pseudo-LRU state store that sits directly upstream of eviction_lru.
- Holds the (ASSOCIATIVITY-1)-bit PLRU tree for every cache set and updates it on each hit or fill ("touch").
- On an eviction request, presents a registered copy of the requested set's tree bits to eviction_lru, which returns block_select.
- Provides a sequential flush that clears every set.

---
 rtl/plru_state_update.sv | 136 +++++++++++++
 tb/tb_plru_state_update.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plru_state_update.sv
// plru_state_update
//   Per-set tree pseudo-LRU state store feeding eviction_lru.
//   Each set keeps an (ASSOCIATIVITY-1)-bit binary tree. Node n has children
//   2n+1 (lower ways) and 2n+2 (higher ways). A node bit of 1 points the
//   victim search to the left subtree, and 0 points it to the right. A touch
//   (hit or fill) therefore writes each node on the path to the touched way
//   with the direction bit of that way, which steers the victim away from it.
//
// Ports
//   clk        rising-edge clock for all state
//   rst_n      synchronous reset, active low
//   acc_valid  touch request this cycle
//   acc_set    set being touched
//   acc_way    way hit or filled
//   evict_req  victim lookup request
//   evict_set  set needing a victim
//   lru_valid  lru_bits carries a fresh lookup result this cycle
//   lru_bits   registered tree bits of the requested set (to eviction_lru)
//   flush_req  start clearing every set
//   busy       flush in progress; touches and lookups are ignored
module plru_state_update #(
  parameter int ASSOCIATIVITY = 8,
  parameter int NUM_SETS      = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               acc_valid,
  input  logic [$clog2(NUM_SETS)-1:0]        acc_set,
  input  logic [$clog2(ASSOCIATIVITY)-1:0]   acc_way,
  input  logic                               evict_req,
  input  logic [$clog2(NUM_SETS)-1:0]        evict_set,
  output logic                               lru_valid,
  output logic [ASSOCIATIVITY-2:0]           lru_bits,
  input  logic                               flush_req,
  output logic                               busy
);

  localparam int L = $clog2(ASSOCIATIVITY);
  localparam int S = $clog2(NUM_SETS);
  localparam int W = ASSOCIATIVITY - 1;

  typedef enum logic {
    IDLE,
    FLUSH
  } fsm_t;

  fsm_t           fsm;
  logic [S-1:0]   flush_cnt;
  logic [W-1:0]   tree_q [NUM_SETS];
  logic [W-1:0]   acc_tree_next;

  // Rewrites the L nodes on the path from the root to 'way'. At level k the
  // path node is the (way >> (L-k))-th node of that level, and it receives
  // the way bit that chooses between its two children.
  function automatic logic [W-1:0] touch_tree(input logic [W-1:0] tree,
                                               input logic [L-1:0] way);
    logic [W-1:0] t;
    logic [L-1:0] upper;
    logic [L-1:0] dir_bits;
    int           node;
    t = tree;
    for (int k = 0; k < L; k++) begin
      upper    = way >> (L - k);
      dir_bits = way >> (L - 1 - k);
      node     = (1 << k) - 1 + int'(upper);
      t        = t & ~(W'(1) << node);
      if (dir_bits[0]) begin
        t = t | (W'(1) << node);
      end
    end
    return t;
  endfunction

  // Updated tree of the touched set; it is both the value written back and
  // the bypass value when the lookup hits the same set in the same cycle.
  always_comb begin
    acc_tree_next = touch_tree(tree_q[acc_set], acc_way);
  end

  // Controller and state store. In IDLE, touches and lookups are serviced
  // every cycle, and a flush request wins over anything presented alongside
  // it. In FLUSH, one set is cleared per cycle, starting at set 0; the cycle
  // that clears the last set also returns to IDLE, so busy lasts NUM_SETS
  // cycles. lru_bits only changes on an accepted lookup or on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        tree_q[s] <= '0;
      end
      fsm       <= IDLE;
      flush_cnt <= '0;
      busy      <= 1'b0;
      lru_valid <= 1'b0;
      lru_bits  <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (flush_req) begin
            fsm       <= FLUSH;
            busy      <= 1'b1;
            flush_cnt <= '0;
            lru_valid <= 1'b0;
          end else begin
            if (acc_valid) begin
              tree_q[acc_set] <= acc_tree_next;
            end
            lru_valid <= evict_req;
            if (evict_req) begin
              // Write-first: a same-set touch is visible to this lookup.
              if (acc_valid && (acc_set == evict_set)) begin
                lru_bits <= acc_tree_next;
              end else begin
                lru_bits <= tree_q[evict_set];
              end
            end
          end
        end
        FLUSH: begin
          tree_q[flush_cnt] <= '0;
          lru_valid         <= 1'b0;
          if (flush_cnt == S'(NUM_SETS - 1)) begin
            fsm       <= IDLE;
            busy      <= 1'b0;
            flush_cnt <= '0;
          end else begin
            flush_cnt <= flush_cnt + S'(1);
          end
        end
        default: begin
          fsm <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_plru_state_update.sv
// tb_plru_state_update
//   Self-checking bench for plru_state_update (8 ways, 16 sets), plus two
//   small instances (2 and 4 ways) used for the "touched way is never the
//   victim" sweep. Expected values come from a table of constants and from a
//   tree-walking model that keeps one bit per node for every set.
module tb_plru_state_update;

  localparam int A  = 8;
  localparam int NS = 16;
  localparam int L  = 3;
  localparam int S  = 4;
  localparam int W  = A - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         acc_valid;
  logic [S-1:0] acc_set;
  logic [L-1:0] acc_way;
  logic         evict_req;
  logic [S-1:0] evict_set;
  logic         lru_valid;
  logic [W-1:0] lru_bits;
  logic         flush_req;
  logic         busy;

  int checks     = 0;
  int passes     = 0;
  int small_done = 0;
  logic small_start = 1'b0;

  // 10 ns clock shared by every instance.
  always #5 clk = ~clk;

  plru_state_update #(.ASSOCIATIVITY(A), .NUM_SETS(NS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .acc_valid (acc_valid),
    .acc_set   (acc_set),
    .acc_way   (acc_way),
    .evict_req (evict_req),
    .evict_set (evict_set),
    .lru_valid (lru_valid),
    .lru_bits  (lru_bits),
    .flush_req (flush_req),
    .busy      (busy)
  );

  // Reference model: per set, one bit per tree node, plus the number of
  // flush cycles still outstanding and the expected registered outputs.
  bit           mtree [NS][W];
  int           busy_left = 0;
  bit           exp_valid = 1'b0;
  bit           exp_busy  = 1'b0;
  logic [W-1:0] exp_bits  = '0;

  task automatic model_clear();
    for (int s = 0; s < NS; s++)
      for (int n = 0; n < W; n++)
        mtree[s][n] = 1'b0;
  endtask

  // Walk from the root toward the touched way, marking each node with the
  // direction taken (1 = went right, so victim goes left).
  task automatic model_touch(input int s, input int w);
    int node;
    int dir;
    node = 0;
    for (int k = 0; k < L; k++) begin
      dir = (w >> (L - 1 - k)) & 1;
      mtree[s][node] = (dir != 0);
      node = 2 * node + 1 + dir;
    end
  endtask

  function automatic logic [W-1:0] pack_set(input int s);
    logic [W-1:0] r;
    r = '0;
    for (int n = 0; n < W; n++)
      if (mtree[s][n]) r = r | (W'(1) << n);
    return r;
  endfunction

  // Follow the tree bits from the root to a leaf; leaves are heap nodes
  // W..2W, so the way number is the leaf index minus W.
  function automatic int victim(input logic [W-1:0] b);
    int node;
    logic [W-1:0] t;
    node = 0;
    while (node < W) begin
      t = b >> node;
      node = t[0] ? 2 * node + 1 : 2 * node + 2;
    end
    return node - W;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
  endtask

  // Drive one cycle of inputs, advance the model by the same clock edge,
  // then wait until just after that edge.
  task automatic applyStimulus(input bit rn, input bit av, input int as, input int aw,
                               input bit er, input int es, input bit fr);
    rst_n     = rn;
    acc_valid = av;
    acc_set   = as[S-1:0];
    acc_way   = aw[L-1:0];
    evict_req = er;
    evict_set = es[S-1:0];
    flush_req = fr;
    if (!rn) begin
      model_clear();
      busy_left = 0;
      exp_valid = 1'b0;
      exp_bits  = '0;
    end else if (busy_left > 0) begin
      busy_left--;
      exp_valid = 1'b0;
    end else if (fr) begin
      model_clear();
      busy_left = NS;
      exp_valid = 1'b0;
    end else begin
      if (av) model_touch(as, aw);
      exp_valid = er;
      if (er) exp_bits = pack_set(es);
    end
    exp_busy = (busy_left > 0);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_busy"},  busy,      exp_busy);
    check({tag, "_valid"}, lru_valid, exp_valid);
    check({tag, "_bits"},  lru_bits,  exp_bits);
  endtask

  typedef struct {
    bit         av;
    int         as;
    int         aw;
    bit         er;
    int         es;
    bit         ev;
    logic [6:0] eb;
    int         evic;
  } vec_t;

  vec_t tbl [10];

  // Small-associativity instances: from reset, touch one way of set 1 and
  // look the set up; the selected victim must differ from the touched way.
  for (genvar gi = 0; gi < 2; gi++) begin : g_small
    localparam int SA = 2 << gi;
    localparam int SL = $clog2(SA);
    localparam int SW = SA - 1;

    logic          s_rst_n;
    logic          s_av;
    logic [1:0]    s_as;
    logic [SL-1:0] s_aw;
    logic          s_er;
    logic [1:0]    s_es;
    logic          s_fr;
    logic          s_valid;
    logic [SW-1:0] s_bits;
    logic          s_busy;

    plru_state_update #(.ASSOCIATIVITY(SA), .NUM_SETS(4)) dut_s (
      .clk       (clk),
      .rst_n     (s_rst_n),
      .acc_valid (s_av),
      .acc_set   (s_as),
      .acc_way   (s_aw),
      .evict_req (s_er),
      .evict_set (s_es),
      .lru_valid (s_valid),
      .lru_bits  (s_bits),
      .flush_req (s_fr),
      .busy      (s_busy)
    );

    function automatic int svictim(input logic [SW-1:0] b);
      int node;
      logic [SW-1:0] t;
      node = 0;
      while (node < SW) begin
        t = b >> node;
        node = t[0] ? 2 * node + 1 : 2 * node + 2;
      end
      return node - SW;
    endfunction

    initial begin
      s_rst_n = 1'b0; s_av = 1'b0; s_as = '0; s_aw = '0;
      s_er = 1'b0; s_es = '0; s_fr = 1'b0;
      wait (small_start);
      @(posedge clk); #1;
      for (int w = 0; w < SA; w++) begin
        s_rst_n = 1'b0;
        @(posedge clk); #1;
        s_rst_n = 1'b1;
        s_av = 1'b1; s_as = 2'd1; s_aw = SL'(w);
        @(posedge clk); #1;
        s_av = 1'b0;
        s_er = 1'b1; s_es = 2'd1;
        @(posedge clk); #1;
        s_er = 1'b0;
        checks++;
        if (s_valid === 1'b1 && !s_busy && svictim(s_bits) != w) passes++;
        else $display("[TB] FAIL small_A%0d_way%0d: valid %0b bits 'h%0h victim %0d, required valid 1 and victim != %0d",
                      SA, w, s_valid, s_bits, svictim(s_bits), w);
      end
      small_done++;
    end
  end

  initial begin
    int busy_cycles;
    bit rn, av, er, fr;
    int as, aw, es;

    tbl[0] = '{0, 0, 0, 1, 3, 1, 7'h00, 7};
    tbl[1] = '{1, 3, 7, 0, 0, 0, 7'h00, -1};
    tbl[2] = '{0, 0, 0, 1, 3, 1, 7'h45, 3};
    tbl[3] = '{1, 3, 0, 0, 0, 0, 7'h45, -1};
    tbl[4] = '{0, 0, 0, 1, 3, 1, 7'h44, 5};
    tbl[5] = '{0, 0, 0, 1, 4, 1, 7'h00, 7};
    tbl[6] = '{1, 2, 7, 1, 2, 1, 7'h45, 3};
    tbl[7] = '{1, 2, 0, 1, 3, 1, 7'h44, 5};
    tbl[8] = '{0, 0, 0, 1, 2, 1, 7'h44, 5};
    tbl[9] = '{0, 0, 0, 0, 0, 0, 7'h44, -1};

    rst_n = 1'b0; acc_valid = 1'b0; acc_set = '0; acc_way = '0;
    evict_req = 1'b0; evict_set = '0; flush_req = 1'b0;
    model_clear();
    @(posedge clk); #1;

    // Reset state, with requests presented during reset being dropped.
    applyStimulus(0, 1, 3, 7, 1, 3, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset");

    // Directed table: touches, lookups, same-set bypass, untouched set.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, tbl[i].av, tbl[i].as, tbl[i].aw, tbl[i].er, tbl[i].es, 0);
      checkOutput($sformatf("tbl%0d", i));
      check($sformatf("tbl%0d_valid_const", i), lru_valid, tbl[i].ev);
      check($sformatf("tbl%0d_bits_const", i), lru_bits, tbl[i].eb);
      if (tbl[i].evic >= 0)
        check($sformatf("tbl%0d_victim", i), victim(lru_bits), tbl[i].evic);
    end

    // Every way of the 8-way instance: touched way is never the victim.
    for (int w = 0; w < A; w++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 1, 5, w, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 1, 5, 0);
      checkOutput($sformatf("excl%0d", w));
      check($sformatf("excl%0d_victim_ne", w), victim(lru_bits) != w, 1);
    end

    // Flush: fill several sets, flush with junk requests while busy, then
    // confirm busy length and that every set reads back zero.
    for (int s = 0; s < 8; s++) begin
      applyStimulus(1, 1, s, s, 0, 0, 0);
      applyStimulus(1, 1, s + 8, 7 - s, 0, 0, 0);
    end
    applyStimulus(1, 1, 1, 3, 1, 1, 1);
    checkOutput("flush_start");
    busy_cycles = busy ? 1 : 0;
    for (int c = 0; c < NS; c++) begin
      applyStimulus(1, 1, $urandom_range(NS - 1), $urandom_range(A - 1), 1,
                    $urandom_range(NS - 1), $urandom_range(1));
      checkOutput($sformatf("flush_c%0d", c));
      if (busy) busy_cycles++;
    end
    check("flush_busy_len", busy_cycles, NS);
    for (int s = 0; s < NS; s++) begin
      applyStimulus(1, 0, 0, 0, 1, s, 0);
      checkOutput($sformatf("post_flush_s%0d", s));
      check($sformatf("post_flush_zero_s%0d", s), lru_bits, 0);
    end

    // Reset in the middle of a flush, then normal operation resumes.
    applyStimulus(1, 1, 6, 2, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    for (int c = 0; c < 5; c++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("midflush_busy");
    applyStimulus(0, 1, 6, 7, 1, 6, 0);
    checkOutput("midflush_reset");
    check("midflush_reset_busy", busy, 0);
    applyStimulus(1, 1, 6, 7, 1, 6, 0);
    checkOutput("after_reset_bypass");
    check("after_reset_bits", lru_bits, 7'h45);
    applyStimulus(1, 0, 0, 0, 1, 9, 0);
    checkOutput("after_reset_other");

    // Randomized traffic with occasional flush and reset.
    for (int c = 0; c < 400; c++) begin
      rn = ($urandom_range(99) != 0);
      av = $urandom_range(1);
      as = ($urandom_range(3) == 0) ? $urandom_range(NS - 1) : $urandom_range(3);
      aw = $urandom_range(A - 1);
      er = $urandom_range(1);
      es = ($urandom_range(1) == 0) ? as : $urandom_range(3);
      fr = ($urandom_range(39) == 0);
      applyStimulus(rn, av, as, aw, er, es, fr);
      checkOutput($sformatf("rand%0d", c));
    end

    // Small-associativity sweep, bounded wait.
    small_start = 1'b1;
    for (int c = 0; c < 500 && small_done < 2; c++) @(posedge clk);
    #1;
    check("small_sweep_done", small_done, 2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
